// File: rtl/axi_rd_slv_ost_pkg.sv
// axi_rd_slv_ost_pkg: bus widths, AXI encodings, AR queue entry and burst address step
package axi_rd_slv_ost_pkg;
    localparam int AXI_ID_WIDTH    = 4;
    localparam int AXI_ADDR_WIDTH  = 32;
    localparam int AXI_LEN_WIDTH   = 8;
    localparam int AXI_SIZE_WIDTH  = 3;
    localparam int AXI_BURST_WIDTH = 2;
    localparam int AXI_DATA_WIDTH  = 64;
    localparam int AXI_RESP_WIDTH  = 2;

    localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_FIXED = 2'd0;
    localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_INCR  = 2'd1;
    localparam logic [AXI_BURST_WIDTH-1:0] AXI_BURST_WRAP  = 2'd2;

    localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_OKAY   = 2'd0;
    localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_SLVERR = 2'd2;
    localparam logic [AXI_RESP_WIDTH-1:0] AXI_RESP_DECERR = 2'd3;

    typedef struct packed {
        logic [AXI_ID_WIDTH-1:0]    id;
        logic [AXI_ADDR_WIDTH-1:0]  addr;
        logic [AXI_LEN_WIDTH-1:0]   len;
        logic [AXI_SIZE_WIDTH-1:0]  size;
        logic [AXI_BURST_WIDTH-1:0] burst;
        logic                       dec_miss;
        logic                       bad;
    } ar_entry_t;

    function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(
        input logic [AXI_ADDR_WIDTH-1:0]  cur,
        input logic [AXI_LEN_WIDTH-1:0]   len,
        input logic [AXI_SIZE_WIDTH-1:0]  size,
        input logic [AXI_BURST_WIDTH-1:0] burst
    );
        logic [AXI_ADDR_WIDTH-1:0] bytes, mask;
        bytes = AXI_ADDR_WIDTH'(1) << size;
        mask  = ((AXI_ADDR_WIDTH'(len) + AXI_ADDR_WIDTH'(1)) << size) - AXI_ADDR_WIDTH'(1);
        return burst == AXI_BURST_INCR ? cur + bytes :
               burst == AXI_BURST_WRAP ? (cur & ~mask) | ((cur + bytes) & mask) : cur;
    endfunction
endpackage

// File: rtl/axi_rd_ost_fifo.sv
// axi_rd_ost_fifo: synchronous FIFO holding queued AR requests; head is the oldest entry
module axi_rd_ost_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push, do_pop;

    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            cnt    <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/axi_rd_slv_ost.sv
// axi_rd_slv_ost: AXI read slave with an outstanding-AR queue, in-order synthetic bursts,
// range decode (DECERR) and error injection (SLVERR)
module axi_rd_slv_ost
    import axi_rd_slv_ost_pkg::*;
#(
    parameter int                        OST_DEPTH  = 4,
    parameter int                        RD_LAT     = 2,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_RANGE = 'h1000,
    parameter logic [AXI_ID_WIDTH-1:0]   ERR_ID     = '1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [AXI_ID_WIDTH-1:0]    axi_slv_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]  axi_slv_araddr,
    input  logic [AXI_LEN_WIDTH-1:0]   axi_slv_arlen,
    input  logic [AXI_SIZE_WIDTH-1:0]  axi_slv_arsize,
    input  logic [AXI_BURST_WIDTH-1:0] axi_slv_arburst,
    input  logic                       axi_slv_arvalid,
    output logic                       axi_slv_arready,
    output logic [AXI_ID_WIDTH-1:0]    axi_slv_rid,
    output logic [AXI_DATA_WIDTH-1:0]  axi_slv_rdata,
    output logic [AXI_RESP_WIDTH-1:0]  axi_slv_rresp,
    output logic                       axi_slv_rlast,
    output logic                       axi_slv_rvalid,
    input  logic                       axi_slv_rready
);
    typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;

    localparam int          OW   = $clog2(OST_DEPTH) + 1;
    localparam logic [3:0]  LAT0 = 4'(RD_LAT == 0 ? 0 : RD_LAT - 1);
    localparam logic [AXI_SIZE_WIDTH-1:0] MAX_SIZE = AXI_SIZE_WIDTH'($clog2(AXI_DATA_WIDTH / 8));

    state_t                    state, state_nxt;
    ar_entry_t                 ar_in, head, cur, cur_nxt;
    logic [AXI_ADDR_WIDTH-1:0] cur_addr, cur_addr_nxt;
    logic [AXI_LEN_WIDTH:0]    beat, beat_nxt;
    logic [3:0]                lat_cnt, lat_nxt;
    logic [OW-1:0]             ost_cnt;
    logic [AXI_ADDR_WIDTH:0]   win_lo, win_hi, addr_x;
    logic                      rdy_en, full, empty, push, load, last, hs, retire;

    assign win_lo = {1'b0, BASE_ADDR};
    assign win_hi = {1'b0, BASE_ADDR} + {1'b0, ADDR_RANGE};
    assign addr_x = {1'b0, axi_slv_araddr};

    assign ar_in = '{
        id:       axi_slv_arid,
        addr:     axi_slv_araddr,
        len:      axi_slv_arlen,
        size:     axi_slv_arsize,
        burst:    axi_slv_arburst,
        dec_miss: addr_x < win_lo || addr_x >= win_hi,
        bad:      axi_slv_arburst == 2'b11
                  || (axi_slv_arburst == AXI_BURST_WRAP && !(axi_slv_arlen inside {8'd1, 8'd3, 8'd7, 8'd15}))
                  || axi_slv_arsize > MAX_SIZE
    };

    // Outstanding count covers the burst in service too, so a popped entry keeps its slot until retired
    assign axi_slv_arready = rdy_en & ~full & (ost_cnt != OW'(OST_DEPTH));
    assign push            = axi_slv_arvalid & axi_slv_arready;
    assign axi_slv_rvalid  = state == DATA;
    assign last            = beat == {1'b0, cur.len};
    assign hs              = axi_slv_rvalid & axi_slv_rready;
    assign retire          = hs & last;
    assign load            = (state == IDLE || retire) && !empty;

    axi_rd_ost_fifo #(.DEPTH(OST_DEPTH), .WIDTH($bits(ar_entry_t))) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (load),
        .din   (ar_in),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    always_comb begin
        state_nxt    = state;
        cur_nxt      = cur;
        cur_addr_nxt = cur_addr;
        beat_nxt     = beat;
        lat_nxt      = lat_cnt;
        if (load) begin
            cur_nxt      = head;
            cur_addr_nxt = head.addr;
            beat_nxt     = '0;
            state_nxt    = (head.dec_miss || RD_LAT == 0) ? DATA : WAIT;
            lat_nxt      = LAT0;
        end else if (retire) begin
            state_nxt = IDLE;
        end else if (hs) begin
            beat_nxt     = beat + (AXI_LEN_WIDTH+1)'(1);
            cur_addr_nxt = next_addr(cur_addr, cur.len, cur.size, cur.burst);
            state_nxt    = (cur.dec_miss || RD_LAT == 0) ? DATA : WAIT;
            lat_nxt      = LAT0;
        end else if (state == WAIT) begin
            state_nxt = lat_cnt == '0 ? DATA : WAIT;
            lat_nxt   = lat_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cur      <= '0;
            cur_addr <= '0;
            beat     <= '0;
            lat_cnt  <= '0;
            ost_cnt  <= '0;
            rdy_en   <= 1'b0;
        end else begin
            state    <= state_nxt;
            cur      <= cur_nxt;
            cur_addr <= cur_addr_nxt;
            beat     <= beat_nxt;
            lat_cnt  <= lat_nxt;
            ost_cnt  <= ost_cnt + OW'(push) - OW'(retire);
            rdy_en   <= 1'b1;
        end
    end

    assign axi_slv_rid   = axi_slv_rvalid ? cur.id : '0;
    assign axi_slv_rlast = axi_slv_rvalid & last;
    assign axi_slv_rdata = (axi_slv_rvalid && !cur.dec_miss) ? AXI_DATA_WIDTH'({cur.id, cur_addr}) : '0;
    assign axi_slv_rresp = !axi_slv_rvalid              ? AXI_RESP_OKAY   :
                           cur.dec_miss                 ? AXI_RESP_DECERR :
                           cur.bad                      ? AXI_RESP_SLVERR :
                           (cur.id == ERR_ID && last)   ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
endmodule

// File: tb/tb_axi_rd_slv_ost.sv
// tb_axi_rd_slv_ost: directed and random AR traffic checked beat-by-beat against a burst-level model
module tb_axi_rd_slv_ost;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  arid = '0;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid;
    logic        rready = 1'b0;

    axi_rd_slv_ost dut (
        .clk(clk), .rst_n(rst_n),
        .axi_slv_arid(arid), .axi_slv_araddr(araddr), .axi_slv_arlen(arlen),
        .axi_slv_arsize(arsize), .axi_slv_arburst(arburst), .axi_slv_arvalid(arvalid),
        .axi_slv_arready(arready),
        .axi_slv_rid(rid), .axi_slv_rdata(rdata), .axi_slv_rresp(rresp),
        .axi_slv_rlast(rlast), .axi_slv_rvalid(rvalid), .axi_slv_rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        bit          chk_data;
    } beat_t;

    beat_t       exp_q[$];
    int          hs_q[$];
    int          last_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc_n = 0;
    int          ar_cyc = 0;
    bit          ar_done = 0;
    bit          rnd_rdy = 0;
    bit          prev_stall = 0;
    logic [3:0]  p_rid;
    logic [63:0] p_rdata;
    logic [1:0]  p_rresp;
    logic        p_rlast, p_rvalid;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc_n);
        end
    endtask

    // Expected beats of one burst, from the address/response rules of the AXI read channel
    task automatic model_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        bit dec = addr >= 32'h1000;
        bit bad = burst == 2'd3 || (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15)) || size > 3;
        longint unsigned a = addr;
        longint unsigned bytes = 64'd1 << size;
        longint unsigned total = (longint'(len) + 1) * bytes;
        longint unsigned base;
        beat_t e;
        for (int b = 0; b <= int'(len); b++) begin
            e.id       = id;
            e.last     = b == int'(len);
            e.resp     = dec ? 2'd3 : bad ? 2'd2 : (id == 4'hF && e.last) ? 2'd2 : 2'd0;
            e.data     = dec ? 64'd0 : {28'd0, id, a[31:0]};
            e.chk_data = dec || !bad;
            exp_q.push_back(e);
            if (burst == 2'd1) a = (a + bytes) & 64'hFFFF_FFFF;
            else if (burst == 2'd2) begin
                base = (a / total) * total;
                a = base + ((a + bytes - base) % total);
            end
        end
    endtask

    task automatic cyc();
        beat_t e;
        @(negedge clk);
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_rvalid", rvalid, p_rvalid);
                chk("stall_rid", rid, p_rid);
                chk("stall_rdata", rdata, p_rdata);
                chk("stall_rresp", rresp, p_rresp);
                chk("stall_rlast", rlast, p_rlast);
            end
            if (rvalid && exp_q.size() == 0) chk("rvalid_unexpected", rvalid, 0);
            else if (rvalid && rready) begin
                e = exp_q.pop_front();
                chk("rid", rid, e.id);
                chk("rresp", rresp, e.resp);
                chk("rlast", rlast, e.last);
                if (e.chk_data) chk("rdata", rdata, e.data);
                hs_q.push_back(cyc_n);
                if (rlast) last_q.push_back(cyc_n);
            end
            if (arvalid && arready) begin
                model_ar(arid, araddr, arlen, arsize, arburst);
                ar_done = 1;
                ar_cyc = cyc_n;
            end
        end
        prev_stall = rst_n && rvalid && !rready;
        p_rvalid = rvalid; p_rid = rid; p_rdata = rdata; p_rresp = rresp; p_rlast = rlast;
        cyc_n++;
        @(posedge clk);
        #1;
        if (rnd_rdy) rready = 1'($urandom_range(0, 1));
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst;
        arvalid = 1; ar_done = 0;
        for (int i = 0; i < 300 && !ar_done; i++) cyc();
        chk("ar_accept", ar_done, 1);
        arvalid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) cyc();
        chk("drain", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lens[4] = '{1, 3, 7, 15};
        logic [1:0]  b;
        logic [31:0] a;
        // reset
        cyc(); cyc();
        chk("rst_arready", arready, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rlast", rlast, 0);
        rst_n = 1;
        cyc();
        chk("arready_after_rst", arready, 1);
        // INCR latency and beat spacing
        rready = 1;
        hs_q.delete();
        send_ar(4'd3, 32'h100, 8'd3, 3'd2, 2'd1);
        drain();
        chk("incr_beats", hs_q.size(), 4);
        chk("incr_first_lat", hs_q[0] - ar_cyc, 4);
        for (int i = 1; i < hs_q.size(); i++) chk("incr_spacing", hs_q[i] - hs_q[i-1], 3);
        // WRAP and FIXED
        send_ar(4'd1, 32'h38, 8'd3, 3'd3, 2'd2);
        drain();
        send_ar(4'd2, 32'h40, 8'd2, 3'd2, 2'd0);
        drain();
        // queue fills, fifth AR held off until first burst retires
        rready = 0;
        hs_q.delete(); last_q.delete();
        for (int i = 0; i < 4; i++) send_ar(4'(i + 1), 32'h200 + 32'(16 * i), 8'd1, 3'd2, 2'd1);
        arid = 4'd5; araddr = 32'h240; arlen = 8'd1; arsize = 3'd2; arburst = 2'd1;
        arvalid = 1; ar_done = 0;
        repeat (8) cyc();
        chk("ar_held_off", ar_done, 0);
        chk("arready_full", arready, 0);
        rready = 1;
        for (int i = 0; i < 100 && !ar_done; i++) cyc();
        arvalid = 0;
        chk("ar5_accept", ar_done, 1);
        chk("ar5_after_drain", ar_cyc, last_q[0] + 1);
        drain();
        chk("ost_beats", hs_q.size(), 10);
        for (int i = 1; i < hs_q.size(); i++) chk("ost_spacing", hs_q[i] - hs_q[i-1], 3);
        // decode window boundaries and error injection
        hs_q.delete();
        send_ar(4'd4, 32'h2000, 8'd1, 3'd2, 2'd1);
        drain();
        chk("decerr_lat", hs_q[0] - ar_cyc, 2);
        chk("decerr_spacing", hs_q[1] - hs_q[0], 1);
        send_ar(4'd6, 32'hFFF, 8'd0, 3'd0, 2'd1);
        drain();
        send_ar(4'd6, 32'h1000, 8'd0, 3'd0, 2'd1);
        drain();
        send_ar(4'hF, 32'h300, 8'd2, 3'd2, 2'd1);
        drain();
        send_ar(4'd7, 32'h400, 8'd1, 3'd2, 2'd3);
        drain();
        send_ar(4'd8, 32'h400, 8'd2, 3'd2, 2'd2);
        drain();
        send_ar(4'd9, 32'h400, 8'd0, 3'd4, 2'd1);
        drain();
        // random traffic with random rready
        rnd_rdy = 1;
        for (int n = 0; n < 14; n++) begin
            b = 2'($urandom_range(0, 2));
            a = ($urandom_range(0, 5) == 0) ? 32'h1000 + $urandom_range(0, 32'hFFFF) : $urandom_range(0, 32'hFFF);
            send_ar(4'($urandom_range(0, 14)), a,
                    b == 2'd2 ? 8'(lens[$urandom_range(0, 3)]) : 8'($urandom_range(0, 7)),
                    3'($urandom_range(0, 3)), b);
        end
        drain();
        rnd_rdy = 0;
        rready = 1;
        // reset in the middle of a burst
        hs_q.delete();
        send_ar(4'd6, 32'h600, 8'd7, 3'd2, 2'd1);
        for (int i = 0; i < 100 && hs_q.size() < 2; i++) cyc();
        chk("pre_rst_beats", hs_q.size(), 2);
        rready = 0;
        rst_n = 0;
        cyc();
        exp_q.delete();
        chk("midrst_rvalid", rvalid, 0);
        chk("midrst_arready", arready, 0);
        rst_n = 1;
        rready = 1;
        cyc();
        chk("postrst_arready", arready, 1);
        repeat (5) cyc();
        send_ar(4'd7, 32'h500, 8'd2, 3'd2, 2'd1);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
